// File: rtl/gpio_switch_debounce.sv
// Debounce and edge-detect for the 32-bit DIP switch word from the GPIO board driver.
// The raw word is synchronised and must hold for STABLE_CYCLES before it is committed.
module gpio_switch_debounce #(
  parameter int WIDTH         = 32,
  parameter int STABLE_CYCLES = 262144
) (
  input  logic             clock_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_valid,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed,
  output logic [WIDTH-1:0] sw_toggle,
  output logic             busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] cand, cand_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] stable_d, rise_d, fall_d, toggle_d;
  logic             valid_d, changed_d;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      cand       <= '0;
      cnt        <= '0;
      state      <= SETTLE;
      sw_stable  <= '0;
      sw_valid   <= 1'b0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      sw_changed <= 1'b0;
      sw_toggle  <= '0;
    end else begin
      sync1      <= sw_raw;
      sync2      <= sync1;
      cand       <= cand_d;
      cnt        <= cnt_d;
      state      <= state_d;
      sw_stable  <= stable_d;
      sw_valid   <= valid_d;
      sw_rise    <= rise_d;
      sw_fall    <= fall_d;
      sw_changed <= changed_d;
      sw_toggle  <= toggle_d;
    end
  end

  // A candidate change always wins and restarts the window, even mid-settle.
  always_comb begin
    state_d   = state;
    cand_d    = cand;
    cnt_d     = cnt;
    stable_d  = sw_stable;
    valid_d   = sw_valid;
    rise_d    = '0;
    fall_d    = '0;
    changed_d = 1'b0;
    toggle_d  = sw_toggle;
    if (sync2 != cand) begin
      cand_d  = sync2;
      cnt_d   = '0;
      state_d = SETTLE;
    end else if (state == SETTLE) begin
      if (cnt == CNT_LAST) begin
        state_d  = IDLE;
        stable_d = cand;
        // First commit after reset only establishes the baseline word.
        if (sw_valid) begin
          rise_d    = cand & ~sw_stable;
          fall_d    = ~cand & sw_stable;
          changed_d = (cand != sw_stable);
          toggle_d  = sw_toggle ^ (cand & ~sw_stable);
        end else begin
          valid_d = 1'b1;
        end
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end
  end

  assign busy = (state == SETTLE);

endmodule
